// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue side of the ALU interface for the multi-cycle RV32I core.
// Accepts one instruction with its operands, decodes it, drives the combinational ALU,
// registers the result and branch outcome, and presents them over a valid/ready writeback.
module alu_issue_ctrl #(
  parameter int XLEN      = 32,
  parameter bit BRANCH_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_lt,
  input  logic            alu_ltu,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_LUI   = 4'd10;
  localparam logic [3:0] OP_AUIPC = 4'd11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // instruction fields and immediates of the incoming word
  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_b_s;

  // decoded values for the incoming word
  logic [31:0] dec_a_s;
  logic [31:0] dec_b_s;
  logic [3:0]  dec_op_s;
  logic        dec_br_s;
  logic        dec_ill_s;
  logic        dec_we_s;
  logic [31:0] dec_tgt_s;

  // decoded values captured at accept, used during EXEC
  logic [31:0] alu_a_r;
  logic [31:0] alu_b_r;
  logic [3:0]  alu_op_r;
  logic [4:0]  rd_r;
  logic [2:0]  f3_r;
  logic        br_r;
  logic        ill_r;
  logic        we_r;
  logic [31:0] tgt_r;

  // writeback side registers
  logic        in_ready_r;
  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic        wb_we_r;
  logic        br_taken_r;
  logic [31:0] br_target_r;
  logic        illegal_r;

  logic        accept_s;
  logic        taken_s;

  assign opc_s   = in_instr[6:0];
  assign f3_s    = in_instr[14:12];
  assign f7_s    = in_instr[31:25];
  assign rd_s    = in_instr[11:7];
  assign imm_i_s = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u_s = {in_instr[31:12], 12'h000};
  assign imm_b_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};

  assign accept_s = (state_r == ST_IDLE) && in_valid;

  // decode the incoming instruction into ALU operands, operation and writeback intent
  always_comb begin
    dec_a_s   = 32'h0000_0000;
    dec_b_s   = 32'h0000_0000;
    dec_op_s  = OP_ADD;
    dec_br_s  = 1'b0;
    dec_ill_s = 1'b0;
    dec_tgt_s = 32'h0000_0000;
    case (opc_s)
      OPC_OP: begin
        dec_a_s = in_rs1;
        dec_b_s = in_rs2;
        if (f7_s == F7_ZERO) begin
          case (f3_s)
            3'b000:  dec_op_s = OP_ADD;
            3'b001:  dec_op_s = OP_SLL;
            3'b010:  dec_op_s = OP_SLT;
            3'b011:  dec_op_s = OP_SLTU;
            3'b100:  dec_op_s = OP_XOR;
            3'b101:  dec_op_s = OP_SRL;
            3'b110:  dec_op_s = OP_OR;
            3'b111:  dec_op_s = OP_AND;
            default: dec_ill_s = 1'b1;
          endcase
        end else if (f7_s == F7_ALT && f3_s == 3'b000) begin
          dec_op_s = OP_SUB;
        end else if (f7_s == F7_ALT && f3_s == 3'b101) begin
          dec_op_s = OP_SRA;
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_a_s = in_rs1;
        dec_b_s = imm_i_s;
        case (f3_s)
          3'b000: dec_op_s = OP_ADD;
          3'b010: dec_op_s = OP_SLT;
          3'b011: dec_op_s = OP_SLTU;
          3'b100: dec_op_s = OP_XOR;
          3'b110: dec_op_s = OP_OR;
          3'b111: dec_op_s = OP_AND;
          3'b001: begin
            // shifts take only the shamt field; the funct7 bits are not operand bits
            dec_b_s = {27'd0, in_instr[24:20]};
            if (f7_s == F7_ZERO) begin
              dec_op_s = OP_SLL;
            end else begin
              dec_ill_s = 1'b1;
            end
          end
          3'b101: begin
            dec_b_s = {27'd0, in_instr[24:20]};
            if (f7_s == F7_ZERO) begin
              dec_op_s = OP_SRL;
            end else if (f7_s == F7_ALT) begin
              dec_op_s = OP_SRA;
            end else begin
              dec_ill_s = 1'b1;
            end
          end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_b_s  = imm_u_s;
        dec_op_s = OP_LUI;
      end
      OPC_AUIPC: begin
        dec_a_s  = in_pc;
        dec_b_s  = imm_u_s;
        dec_op_s = OP_AUIPC;
      end
      OPC_BRANCH: begin
        if (BRANCH_EN && f3_s != 3'b010 && f3_s != 3'b011) begin
          dec_a_s   = in_rs1;
          dec_b_s   = in_rs2;
          dec_op_s  = OP_SUB;
          dec_br_s  = 1'b1;
          dec_tgt_s = in_pc + imm_b_s;
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      default: dec_ill_s = 1'b1;
    endcase
    // an illegal word must not leak partial operands into the ALU
    if (dec_ill_s) begin
      dec_a_s  = 32'h0000_0000;
      dec_b_s  = 32'h0000_0000;
      dec_op_s = OP_ADD;
    end else begin
      dec_op_s = dec_op_s;
    end
    dec_we_s = !dec_ill_s && !dec_br_s && (rd_s != 5'd0);
  end

  // branch condition from the ALU flags of the captured compare
  always_comb begin
    taken_s = 1'b0;
    case (f3_r)
      3'b000:  taken_s = alu_zero;
      3'b001:  taken_s = !alu_zero;
      3'b100:  taken_s = alu_lt;
      3'b101:  taken_s = !alu_lt;
      3'b110:  taken_s = alu_ltu;
      3'b111:  taken_s = !alu_ltu;
      default: taken_s = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic: accept, one execute cycle, then hold writeback until consumed
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_WB;
      ST_WB: begin
        if (wb_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WB;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // handshake flags registered to mirror the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b1;
      wb_valid_r <= 1'b0;
    end else begin
      in_ready_r <= (state_next_s == ST_IDLE);
      wb_valid_r <= (state_next_s == ST_WB);
    end
  end

  // capture decoded operands on accept; they hold until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r  <= 32'h0000_0000;
      alu_b_r  <= 32'h0000_0000;
      alu_op_r <= OP_ADD;
      rd_r     <= 5'd0;
      f3_r     <= 3'd0;
      br_r     <= 1'b0;
      ill_r    <= 1'b0;
      we_r     <= 1'b0;
      tgt_r    <= 32'h0000_0000;
    end else if (accept_s) begin
      alu_a_r  <= dec_a_s;
      alu_b_r  <= dec_b_s;
      alu_op_r <= dec_op_s;
      rd_r     <= rd_s;
      f3_r     <= f3_s;
      br_r     <= dec_br_s;
      ill_r    <= dec_ill_s;
      we_r     <= dec_we_s;
      tgt_r    <= dec_tgt_s;
    end else begin
      alu_a_r  <= alu_a_r;
      alu_b_r  <= alu_b_r;
      alu_op_r <= alu_op_r;
      rd_r     <= rd_r;
      f3_r     <= f3_r;
      br_r     <= br_r;
      ill_r    <= ill_r;
      we_r     <= we_r;
      tgt_r    <= tgt_r;
    end
  end

  // register the ALU outcome at the end of the execute cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd_r     <= 5'd0;
      wb_data_r   <= 32'h0000_0000;
      wb_we_r     <= 1'b0;
      br_taken_r  <= 1'b0;
      br_target_r <= 32'h0000_0000;
      illegal_r   <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      wb_rd_r     <= rd_r;
      wb_data_r   <= alu_result;
      wb_we_r     <= we_r;
      br_taken_r  <= br_r && taken_s;
      br_target_r <= br_r ? tgt_r : 32'h0000_0000;
      illegal_r   <= ill_r;
    end else begin
      wb_rd_r     <= wb_rd_r;
      wb_data_r   <= wb_data_r;
      wb_we_r     <= wb_we_r;
      br_taken_r  <= br_taken_r;
      br_target_r <= br_target_r;
      illegal_r   <= illegal_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign wb_valid  = wb_valid_r;
  assign wb_rd     = wb_rd_r;
  assign wb_data   = wb_data_r;
  assign wb_we     = wb_we_r;
  assign br_taken  = br_taken_r;
  assign br_target = br_target_r;
  assign illegal   = illegal_r;

endmodule
